gt_compare_arbiter: RTL and testbench
=====================================

// Module: gt_compare_arbiter
// PURPOSE
//  Shares one WIDTH-bit unsigned greater-than comparator among NREQ requesters.
//  Each requester presents an operand pair (a,b); the block grants requesters
//  round-robin, evaluates a>b and returns a tagged result on a valid/ready port.
//  It sits between the per-channel operand sources and the result consumer.
// PARAMETERS
//  WIDTH  3  operand width in bits (unsigned)
//  NREQ   4  number of requesters (>=2); IDW = $clog2(NREQ)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  req_valid  in   NREQ        requester i has an operand pair pending
//  req_a      in   NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH  operand b, same packing
//  req_ready  out  NREQ        one-hot grant; pair i is accepted when valid&ready
//  rsp_valid  out  1           result available
//  rsp_id     out  IDW         index of the requester that owns the result
//  rsp_gt     out  1           1 iff a > b (unsigned), else 0 (equal -> 0)
//  rsp_ready  in   1           consumer accepts the result when valid&ready
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0,
//    rsp_id=0, rsp_gt=0, operand registers=0. Deassertion is synchronous.
//  - FSM: IDLE -> CMP -> RESP -> IDLE.
//    IDLE: req_ready is combinational, one-hot for the first valid requester at
//      or after rr_ptr (wrapping NREQ-1 -> 0); 0 if none valid. On a grant,
//      latch a/b/id and go to CMP; rr_ptr <= (winner+1) mod NREQ. No valid
//      request: stay in IDLE, rr_ptr unchanged.
//    CMP: the comparator sees the latched operands; register rsp_gt and rsp_id,
//      set rsp_valid; go to RESP. req_ready=0.
//    RESP: hold rsp_valid/rsp_id/rsp_gt stable until rsp_ready=1; on that edge
//      clear rsp_valid and return to IDLE. req_ready=0 throughout.
//  - Latency: grant edge -> rsp_valid high 2 cycles later. Minimum period is
//    3 cycles per comparison (rsp_ready tied high).
//  - req_ready is never asserted outside IDLE and never to a requester with
//    req_valid=0. Requesters must hold a/b stable while valid&&!ready.
//  - Simultaneous requests: exactly one grant per IDLE cycle. A continuously
//    requesting channel waits at most NREQ-1 other grants.
//  - Back-pressure: with rsp_ready=0 the block stays in RESP indefinitely and
//    grants nothing. Operands are not re-sampled.
//  - Reset mid-operation discards any latched pair or pending result. There
//    is no replay, and rr_ptr returns to 0.
//  - Comparison is purely unsigned over WIDTH bits: (7,0)->1, (0,7)->0,
//    (5,5)->0.
// STRUCTURE
//  - Package gt_cmp_arb_pkg: state enum (IDLE, CMP, RESP, 2-bit encoding) and
//    the IDW helper.
//  - Sub-module gt_compare #(WIDTH): combinational res = (a > b). This is the
//    only instance in this block. The arbiter pick is a local function, not a
//    module.
// TESTING
//  1. Reset: hold rst_n=0 with req_valid=4'b1111 -> req_ready=0, rsp_valid=0,
//     rsp_id=0, rsp_gt=0.
//  2. Single request: req 2 with (a=3'b100, b=3'b011) and rsp_ready=1 ->
//     req_ready=4'b0100 for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=2,
//     rsp_gt=1. Repeat with (3'b010, 3'b100) -> rsp_gt=0; (3'b000, 3'b000) ->
//     rsp_gt=0.
//  3. Round-robin: all 4 valid continuously with rsp_ready=1 -> rsp_id
//     sequence 0,1,2,3,0 with one result every 3 cycles.
//  4. Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid -> outputs
//     stable, req_ready=0. Raise rsp_ready -> accepted in 1 cycle, next grant
//     follows on the next cycle.
//  5. Wrap/skip: rr_ptr=3 with only req 1 valid -> grant 4'b0010, then
//     rr_ptr=2.
//  6. Async reset asserted in CMP and again in RESP -> all outputs 0
//     immediately (before the next clk edge), pending result lost, first
//     grant after release goes to req 0 when all are valid.
//  Exhaustive check: all 64 (a,b) pairs through requester 1 vs a reference
//  model (a>b).

Source files
------------

// File: rtl/gt_cmp_arb_pkg.sv
// Shared types and helpers for the round-robin greater-than compare arbiter.
package gt_cmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester-index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gt_compare.sv
// Combinational unsigned greater-than comparator.
module gt_compare #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res
);

  assign res = (a > b);

endmodule

// File: rtl/gt_compare_arbiter.sv
// Round-robin arbiter sharing one unsigned a>b comparator among NREQ requesters,
// returning a tagged result over a valid/ready port.
module gt_compare_arbiter
  import gt_cmp_arb_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int NREQ  = 4,
  localparam int IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_gt,
  input  logic                  rsp_ready
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             pick_found;
  logic [IDW-1:0]   pick_id;
  logic [IDW-1:0]   next_ptr;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  logic             grant;
  logic             cmp_res;

  // Search starts at ptr and wraps; returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign {pick_found, pick_id} = rr_pick(req_valid, rr_ptr);
  assign pick_a   = req_a[int'(pick_id)*WIDTH +: WIDTH];
  assign pick_b   = req_b[int'(pick_id)*WIDTH +: WIDTH];
  assign next_ptr = (int'(pick_id) == NREQ-1) ? '0 : pick_id + 1'b1;

  // Gated by rst_n so no grant is visible while reset is held.
  assign grant = rst_n && (state == IDLE) && pick_found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[pick_id] = 1'b1;
  end

  gt_compare #(.WIDTH(WIDTH)) u_cmp (
    .a   (a_q),
    .b   (b_q),
    .res (cmp_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            a_q    <= pick_a;
            b_q    <= pick_b;
            id_q   <= pick_id;
            rr_ptr <= next_ptr;
            state  <= CMP;
          end
        end
        CMP: begin
          rsp_gt    <= cmp_res;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gt_compare_arbiter.sv
// Scoreboard bench for gt_compare_arbiter: a transaction model predicts grants
// and queues expected results, which are compared while the DUT presents them.
module tb_gt_compare_arbiter;

  localparam int WIDTH = 3;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_gt;
  logic                  rsp_ready;

  typedef struct {
    int id;
    bit gt;
  } exp_t;

  exp_t            sb[$];
  int              seen_ids[$];
  int              check_count = 0;
  int              fail_count  = 0;
  int              m_state     = 0;
  int              m_ptr       = 0;
  int              exp_id;
  logic [NREQ-1:0] exp_grant;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  exp_t            e;

  gt_compare_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setOperands(input int idx, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
    req_valid = valid;
    rsp_ready = ready;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Cycle-level transaction model: 0 = waiting for grant, 1 = comparing, 2 = result.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("rst_rsp_id",    32'(rsp_id),    32'h0);
      checkOutput("rst_rsp_gt",    32'(rsp_gt),    32'h0);
      m_state = 0;
      m_ptr   = 0;
      sb.delete();
    end else begin
      case (m_state)
        0: begin
          exp_grant = '0;
          exp_id    = 0;
          for (int k = 0; k < NREQ; k++) begin
            if (exp_grant == '0 && req_valid[(m_ptr + k) % NREQ]) begin
              exp_id    = (m_ptr + k) % NREQ;
              exp_grant = NREQ'(1) << exp_id;
            end
          end
          checkOutput("grant", 32'(req_ready), 32'(exp_grant));
          checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'h0);
          if (exp_grant != '0) begin
            ma   = req_a[exp_id*WIDTH +: WIDTH];
            mb   = req_b[exp_id*WIDTH +: WIDTH];
            e.id = exp_id;
            e.gt = (ma > mb);
            sb.push_back(e);
            m_ptr   = (exp_id + 1) % NREQ;
            m_state = 1;
          end
        end
        1: begin
          checkOutput("cmp_req_ready", 32'(req_ready), 32'h0);
          checkOutput("cmp_rsp_valid", 32'(rsp_valid), 32'h0);
          m_state = 2;
        end
        default: begin
          checkOutput("resp_req_ready", 32'(req_ready), 32'h0);
          checkOutput("resp_rsp_valid", 32'(rsp_valid), 32'h1);
          checkOutput("sb_depth", 32'(sb.size()), 32'h1);
          if (sb.size() > 0) begin
            checkOutput("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            checkOutput("rsp_gt", 32'(rsp_gt), 32'(sb[0].gt));
            if (rsp_ready) begin
              seen_ids.push_back(int'(rsp_id));
              void'(sb.pop_front());
              m_state = 0;
            end
          end
        end
      endcase
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    rst_n     = 1'b1;
    req_a     = '0;
    req_b     = '0;
    applyStimulus(4'b1111, 1'b1);
    #2 rst_n  = 1'b0;

    // Reset with every requester asking.
    tick();
    tick();
    checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_rsp_id",    32'(rsp_id),    32'h0);
    checkOutput("reset_rsp_gt",    32'(rsp_gt),    32'h0);
    applyStimulus(4'b0000, 1'b1);
    rst_n = 1'b1;
    tick();

    // Single requester 2 with three operand patterns.
    for (int p = 0; p < 3; p++) begin
      case (p)
        0:       setOperands(2, 3'b100, 3'b011);
        1:       setOperands(2, 3'b010, 3'b100);
        default: setOperands(2, 3'b000, 3'b000);
      endcase
      applyStimulus(4'b0100, 1'b1);
      #1 checkOutput("single_grant", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      tick();
      tick();
    end

    // Round-robin with everyone requesting continuously.
    doReset();
    setOperands(0, 3'd7, 3'd0);
    setOperands(1, 3'd0, 3'd7);
    setOperands(2, 3'd5, 3'd5);
    setOperands(3, 3'd6, 3'd2);
    seen_ids.delete();
    applyStimulus(4'b1111, 1'b1);
    repeat (15) tick();
    req_valid = '0;
    checkOutput("rr_count", 32'(seen_ids.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < seen_ids.size()) checkOutput("rr_seq", 32'(seen_ids[i]), 32'(exp_seq[i]));
    tick();
    tick();

    // Back-pressure: result held while others keep requesting.
    applyStimulus(4'b0001, 1'b0);
    tick();
    req_valid = 4'b1111;
    tick();
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    repeat (10) tick();
    checkOutput("bp_hold_ready", 32'(req_ready), 32'h0);
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_next_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    tick();

    // Wrap and skip: pointer at 3, only requester 1 asking.
    doReset();
    applyStimulus(4'b0100, 1'b1);
    tick();
    req_valid = '0;
    tick();
    tick();
    setOperands(1, 3'd3, 3'd1);
    req_valid = 4'b0010;
    #1 checkOutput("wrap_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    req_valid = 4'b1111;
    #1 checkOutput("ptr2_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    tick();

    // Async reset while comparing, then while presenting a result.
    doReset();
    setOperands(0, 3'd7, 3'd0);
    applyStimulus(4'b1111, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("cmp_rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("cmp_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    #1 checkOutput("cmp_rst_regrant", 32'(req_ready), 32'h1);
    tick();
    tick();
    checkOutput("resp_pre_rst_gt", 32'(rsp_gt), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("resp_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("resp_rst_rsp_gt",    32'(rsp_gt),    32'h0);
    checkOutput("resp_rst_rsp_id",    32'(rsp_id),    32'h0);
    checkOutput("resp_rst_req_ready", 32'(req_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    #1 checkOutput("resp_rst_regrant", 32'(req_ready), 32'h1);
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    tick();

    // Every operand pair through requester 1.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        setOperands(0, 3'($urandom_range(7)), 3'($urandom_range(7)));
        setOperands(1, 3'(a), 3'(b));
        applyStimulus(4'b0010, 1'b1);
        tick();
        req_valid = '0;
        tick();
        tick();
      end
    end

    applyStimulus(4'b0000, 1'b1);
    repeat (3) tick();
    checkOutput("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
